// File: rtl/apb_bdmac_mc.sv
// apb_bdmac_mc: multi-channel APB register file and playback sequencer for the buzzer DMA path.
// Optional completion interrupt (IRQ_STATUS/IRQ_EN) enabled by defining BDMAC_IRQ_EN.
module apb_bdmac_mc #(
  parameter int NCH = 4,
  parameter int AW  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [11:0]       PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic [NCH-1:0]    ch_done,
  output logic [NCH*AW-1:0] ch_start_addr,
  output logic [NCH-1:0]    ch_playing,
  output logic [NCH-1:0]    ch_pause,
  output logic [NCH-1:0]    grant,
  output logic              irq
);
  logic [1:0]     r;
  logic           ch_hit, g_hit, wr, found, unused_ok;
  logic [1:0]     bp;
  logic [31:0]    g_rd;
  logic [NCH-1:0] rsel, wsel, fin, act, gnt_d;
  logic [NCH-1:0] play_q, play_d, stop_q, stop_d, cyc_q, cyc_d;
  logic [1:0]     pri_q [NCH];
  logic [1:0]     pri_d [NCH];
  logic [AW-1:0]  start_q [NCH];
  logic [AW-1:0]  start_d [NCH];
  logic [15:0]    loop_q [NCH];
  logic [15:0]    loop_d [NCH];
  logic [15:0]    rem_q [NCH];
  logic [15:0]    rem_d [NCH];
  assign r         = PADDR[3:2];
  assign ch_hit    = PADDR[11:8] == 4'h0 && {1'b0, PADDR[7:4]} < 5'(NCH);
  assign g_hit     = PADDR[11:4] == 8'h10 && r != 2'd3;
  assign wr        = PSEL & PENABLE & PWRITE;
  assign PSLVERR   = PSEL & PENABLE & ~(ch_hit | g_hit);
  assign PREADY    = 1'b1;
  assign act       = play_q & ~stop_q;
  assign unused_ok = ^PADDR[1:0];
  assign ch_playing = play_q;
  assign ch_pause   = stop_q;
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign rsel[i] = ch_hit && PADDR[7:4] == 4'(i);
    assign wsel[i] = wr & rsel[i];
    // completion: last loop of a non-cyclic stream
    assign fin[i]  = ch_done[i] & play_q[i] & ~cyc_q[i] & (rem_q[i] == 16'd0);
    assign ch_start_addr[i*AW +: AW] = start_q[i];
  end
  always_comb begin
    play_d  = play_q;
    stop_d  = stop_q;
    cyc_d   = cyc_q;
    pri_d   = pri_q;
    start_d = start_q;
    loop_d  = loop_q;
    rem_d   = rem_q;
    for (int c = 0; c < NCH; c++) begin
      if (wsel[c] && r == 2'd0) start_d[c] = PWDATA[AW-1:0];
      if (wsel[c] && r == 2'd2) loop_d[c] = PWDATA[15:0];
      if (wsel[c] && r == 2'd1) begin
        play_d[c] = PWDATA[0];
        stop_d[c] = PWDATA[1];
        cyc_d[c]  = PWDATA[2];
        pri_d[c]  = PWDATA[5:4];
        if (PWDATA[0] && !play_q[c]) rem_d[c] = loop_q[c];
      end
      // end-of-stream uses pre-write state and overrides PLAY/REM from a same-cycle CTRL write
      if (ch_done[c] && play_q[c]) begin
        play_d[c] = ~fin[c];
        rem_d[c]  = (cyc_q[c] | fin[c]) ? rem_q[c] : rem_q[c] - 16'd1;
      end
    end
  end
  always_comb begin
    gnt_d = '0;
    found = 1'b0;
    bp    = 2'd0;
    for (int c = 0; c < NCH; c++) begin
      if (act[c] && (!found || pri_q[c] > bp)) begin
        gnt_d    = '0;
        gnt_d[c] = 1'b1;
        found    = 1'b1;
        bp       = pri_q[c];
      end
    end
  end
  always_comb begin
    PRDATA = g_hit ? g_rd : 32'd0;
    for (int c = 0; c < NCH; c++) begin
      if (rsel[c]) PRDATA = r == 2'd0 ? 32'(start_q[c]) :
                            r == 2'd1 ? {26'd0, pri_q[c], 1'b0, cyc_q[c], stop_q[c], play_q[c]} :
                            r == 2'd2 ? {16'd0, loop_q[c]} : {15'd0, act[c], rem_q[c]};
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      play_q <= '0;
      stop_q <= '0;
      cyc_q  <= '0;
      grant  <= '0;
      for (int c = 0; c < NCH; c++) begin
        pri_q[c]   <= '0;
        start_q[c] <= '0;
        loop_q[c]  <= '0;
        rem_q[c]   <= '0;
      end
    end else begin
      play_q  <= play_d;
      stop_q  <= stop_d;
      cyc_q   <= cyc_d;
      grant   <= gnt_d;
      pri_q   <= pri_d;
      start_q <= start_d;
      loop_q  <= loop_d;
      rem_q   <= rem_d;
    end
  end
`ifdef BDMAC_IRQ_EN
  logic [NCH-1:0] irqs_q, irqs_d, irqe_q, irqe_d;
  // a completion in the same cycle as its W1C keeps the bit set
  always_comb begin
    irqe_d = (wr && g_hit && r == 2'd1) ? PWDATA[NCH-1:0] : irqe_q;
    irqs_d = (irqs_q & ~((wr && g_hit && r == 2'd0) ? PWDATA[NCH-1:0] : '0)) | fin;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irqs_q <= '0;
      irqe_q <= '0;
    end else begin
      irqs_q <= irqs_d;
      irqe_q <= irqe_d;
    end
  end
  assign g_rd = r == 2'd0 ? 32'(irqs_q) : r == 2'd1 ? 32'(irqe_q) : 32'(NCH);
  assign irq  = |(irqs_q & irqe_q);
`else
  assign g_rd = r == 2'd2 ? 32'(NCH) : 32'd0;
  assign irq  = 1'b0;
`endif
endmodule

// File: tb/tb_apb_bdmac_mc.sv
// tb_apb_bdmac_mc: directed scoreboard bench for apb_bdmac_mc (NCH=4, AW=32).
module tb_apb_bdmac_mc;
  localparam int NCH = 4;
  localparam int AW  = 32;
`ifdef BDMAC_IRQ_EN
  localparam logic IRQ = 1'b1;
`else
  localparam logic IRQ = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [11:0] PADDR = '0;
  logic [31:0] PWDATA = '0, PRDATA;
  logic PREADY, PSLVERR, irq;
  logic [NCH-1:0] ch_done = '0, ch_playing, ch_pause, grant;
  logic [NCH*AW-1:0] ch_start_addr;
  logic [32:0] sb[$];
  int n_run = 0, n_fail = 0;

  apb_bdmac_mc #(.NCH(NCH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .ch_done(ch_done), .ch_start_addr(ch_start_addr), .ch_playing(ch_playing),
    .ch_pause(ch_pause), .grant(grant), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [32:0] obs);
    logic [32:0] e;
    n_run++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL %s obs=%h exp=<empty scoreboard>", tag, obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s obs=%h exp=%h", tag, obs, e);
      end
    end
  endtask

  task automatic sig(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    sb.push_back(exp);
    chk(tag, obs);
  endtask

  task automatic apb_wr(input logic [11:0] a, input logic [31:0] d, input logic [NCH-1:0] dn = '0);
    @(posedge clk); #1;
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = a; PWDATA = d;
    @(posedge clk); #1;
    PENABLE = 1'b1; ch_done = dn;
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; ch_done = '0;
  endtask

  task automatic apb_rd(input string tag, input logic [11:0] a, input logic [31:0] exp, input logic err = 1'b0);
    sb.push_back({err, exp});
    @(posedge clk); #1;
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = a;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    @(negedge clk);
    chk(tag, {PSLVERR, PRDATA});
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic pulse(input int c);
    @(posedge clk); #1;
    ch_done = '0;
    ch_done[c] = 1'b1;
    @(posedge clk); #1;
    ch_done = '0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    apb_rd("rst_start0", 12'h000, 32'h0);
    apb_rd("rst_ctrl0", 12'h004, 32'h0);
    apb_rd("rst_stat0", 12'h00C, 32'h0);
    apb_rd("rst_irqs", 12'h100, 32'h0);
    apb_rd("rst_info", 12'h108, 32'(NCH));
    sig("rst_grant", 33'(grant), 33'h0);
    sig("rst_irq", 33'(irq), 33'h0);
    // loop count: LOOP=2 gives three pulses before completion
    apb_wr(12'h008, 32'd2);
    apb_wr(12'h004, 32'h1);
    apb_wr(12'h104, 32'h1);
    apb_rd("loop_stat2", 12'h00C, 32'h0001_0002);
    sig("loop_play", 33'(ch_playing), 33'h1);
    pulse(0);
    apb_rd("loop_stat1", 12'h00C, 32'h0001_0001);
    pulse(0);
    apb_rd("loop_stat0", 12'h00C, 32'h0001_0000);
    sig("loop_irq_pre", 33'(irq), 33'h0);
    pulse(0);
    sig("loop_irq", 33'(irq), 33'(IRQ));
    sig("loop_done_play", 33'(ch_playing), 33'h0);
    apb_rd("loop_stat_end", 12'h00C, 32'h0);
    apb_rd("loop_irqs", 12'h100, 32'(IRQ));
    apb_wr(12'h100, 32'h1);
    sig("w1c_irq", 33'(irq), 33'h0);
    apb_rd("w1c_irqs", 12'h100, 32'h0);
    // cyclic playback never counts down
    apb_wr(12'h018, 32'd7);
    apb_wr(12'h014, 32'h5);
    apb_rd("cyc_stat", 12'h01C, 32'h0001_0007);
    for (int k = 0; k < 10; k++) pulse(1);
    apb_rd("cyc_stat_after", 12'h01C, 32'h0001_0007);
    sig("cyc_play", 33'(ch_playing), 33'h2);
    sig("cyc_irq", 33'(irq), 33'h0);
    // back-to-back pulses and a redundant PLAY write
    apb_wr(12'h008, 32'd3);
    apb_wr(12'h004, 32'h1);
    @(posedge clk); #1 ch_done = 4'b0001;
    @(posedge clk); #1;
    @(posedge clk); #1 ch_done = '0;
    apb_rd("b2b_stat", 12'h00C, 32'h0001_0001);
    apb_wr(12'h004, 32'h1);
    apb_rd("replay_stat", 12'h00C, 32'h0001_0001);
    apb_wr(12'h004, 32'h0);
    apb_wr(12'h014, 32'h0);
    // arbitration
    apb_wr(12'h004, 32'h11);
    apb_wr(12'h024, 32'h31);
    sig("arb_lat1", 33'(grant), 33'h1);
    @(posedge clk); #1;
    sig("arb_pri3", 33'(grant), 33'h4);
    apb_wr(12'h024, 32'h33);
    @(posedge clk); #1;
    sig("arb_stop", 33'(grant), 33'h1);
    sig("arb_pause", 33'(ch_pause), 33'h4);
    apb_rd("arb_stat2", 12'h02C, 32'h0);
    apb_wr(12'h034, 32'h11);
    @(posedge clk); #1;
    sig("arb_tie", 33'(grant), 33'h1);
    apb_wr(12'h034, 32'h21);
    @(posedge clk); #1;
    sig("arb_ch3", 33'(grant), 33'h8);
    apb_wr(12'h030, 32'hDEAD_BEEF);
    sig("start3_out", 33'(ch_start_addr[3*AW +: AW]), 33'hDEAD_BEEF);
    apb_rd("start3_rd", 12'h030, 32'hDEAD_BEEF);
    // collision: completion beats a same-cycle PLAY write, PRI still lands
    apb_wr(12'h004, 32'h0);
    apb_wr(12'h008, 32'h0);
    apb_wr(12'h004, 32'h1);
    apb_wr(12'h004, 32'h21, 4'b0001);
    sig("col_play", 33'(ch_playing), 33'hC);
    apb_rd("col_ctrl", 12'h004, 32'h20);
    sig("col_irq", 33'(irq), 33'(IRQ));
    // collision: completion beats a same-cycle W1C
    apb_wr(12'h004, 32'h1);
    apb_wr(12'h100, 32'h1, 4'b0001);
    apb_rd("col_irqs", 12'h100, 32'(IRQ));
    sig("col_play2", 33'(ch_playing), 33'hC);
    // unmapped accesses
    apb_rd("err_1f0", 12'h1F0, 32'h0, 1'b1);
    apb_rd("err_ch5", 12'h050, 32'h0, 1'b1);
    apb_rd("err_10c", 12'h10C, 32'h0, 1'b1);
    apb_wr(12'h054, 32'h1);
    apb_wr(12'h058, 32'h9);
    sig("err_play", 33'(ch_playing), 33'hC);
    apb_rd("err_alias_ctrl1", 12'h014, 32'h0);
    apb_rd("err_alias_loop1", 12'h018, 32'h7);
    // reset mid-playback
    apb_wr(12'h038, 32'd5);
    apb_wr(12'h034, 32'h0);
    apb_wr(12'h034, 32'h21);
    apb_rd("mid_stat3", 12'h03C, 32'h0001_0005);
    @(posedge clk); #1;
    ch_done = 4'b1000;
    rst_n = 1'b0;
    #2;
    sig("mid_rst_play", 33'(ch_playing), 33'h0);
    sig("mid_rst_grant", 33'(grant), 33'h0);
    sig("mid_rst_irq", 33'(irq), 33'h0);
    @(posedge clk); #1 ch_done = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    apb_rd("post_stat3", 12'h03C, 32'h0);
    apb_rd("post_ctrl3", 12'h034, 32'h0);
    apb_rd("post_start3", 12'h030, 32'h0);
    apb_rd("post_irqs", 12'h100, 32'h0);
    sig("post_grant", 33'(grant), 33'h0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
